// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the flexible synchronous FIFO: width functions and the
// error-status record carried by the top level.
package sync_fifo_pkg;

    // Width needed to hold an occupancy value in the range 0..depth.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width needed to address depth entries; never below one bit.
    function automatic int ptr_w(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

    // One-cycle error pulses raised when a request is dropped.
    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

endpackage

// File: rtl/sync_fifo_flex_if.sv
// Handshake/data bundle between a producer/consumer and sync_fifo_flex.
// master: the side that writes and reads the FIFO; slave: the FIFO itself.
interface sync_fifo_flex_if
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
);
    localparam int CNT_W = cnt_w(DEPTH);

    logic                  w_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  r_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CNT_W-1:0]      count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output w_en, data_in, r_en,
        input  data_out, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  w_en, data_in, r_en,
        output data_out, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_ptr.sv
// Wrapping entry pointer for sync_fifo_flex. Counts 0..DEPTH-1 and wraps
// explicitly, so DEPTH does not need to be a power of two.
module sync_fifo_ptr
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PW   = ptr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [PW-1:0] r_ptr;

    // Advance on each accepted operation, wrapping from the last entry to 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
        end
    end

    assign ptr = r_ptr;

endmodule

// File: rtl/sync_fifo_flex.sv
// Parametrised single-clock FIFO with arbitrary DEPTH, occupancy count,
// programmable almost-full/almost-empty thresholds and overflow/underflow
// pulses. Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads;
// otherwise data_out is registered with one cycle of read latency.
module sync_fifo_flex
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    sync_fifo_flex_if.slave bus
);

    localparam int CNT_W = cnt_w(DEPTH);
    localparam int PW    = ptr_w(DEPTH);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_LEVEL);

    // Illegal configurations stop elaboration.
    generate
        if (DEPTH < 2) begin : g_bad_depth
            $error("sync_fifo_flex: DEPTH must be at least 2");
        end
        if (DATA_WIDTH < 1) begin : g_bad_width
            $error("sync_fifo_flex: DATA_WIDTH must be at least 1");
        end
        if (!(AE_LEVEL >= 0 && AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_levels
            $error("sync_fifo_flex: need 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             r_empty;
    logic             r_almost_full;
    logic             r_almost_empty;
    fifo_err_t        r_err;

    logic [PW-1:0]    w_wr_ptr;
    logic [PW-1:0]    w_rd_ptr;
    logic             w_rd_acc;
    logic             w_wr_acc;
    logic [CNT_W-1:0] w_count_next;

    // A read needs data; a write needs space, or a read freeing a slot in
    // the same cycle (which lets a full FIFO stream at full rate).
    assign w_rd_acc = bus.r_en & ~r_empty;
    assign w_wr_acc = bus.w_en & (~r_full | w_rd_acc);

    sync_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_wr_acc),
        .ptr   (w_wr_ptr)
    );

    sync_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_rd_acc),
        .ptr   (w_rd_ptr)
    );

    // Storage write port; contents survive reset, only the pointers clear.
    always_ff @(posedge clk) begin
        if (rst_n && w_wr_acc) begin
            r_mem[w_wr_ptr] <= bus.data_in;
        end
    end

    // Occupancy moves only when exactly one side is accepted.
    always_comb begin
        w_count_next = r_count;
        unique case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // Count, status flags and error pulses, all taken from the next count so
    // they change on the same edge as the occupancy they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= (AF_LEVEL == 0);
            r_almost_empty <= 1'b1;
            r_err          <= '0;
        end else begin
            r_count         <= w_count_next;
            r_full          <= (w_count_next == CNT_FULL);
            r_empty         <= (w_count_next == '0);
            r_almost_full   <= (w_count_next >= CNT_AF);
            r_almost_empty  <= (w_count_next <= CNT_AE);
            r_err.overflow  <= bus.w_en & ~w_wr_acc;
            r_err.underflow <= bus.r_en & ~w_rd_acc;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head of queue is presented continuously; r_en acknowledges it.
    assign bus.data_out = r_mem[w_rd_ptr];
`else
    logic [DATA_WIDTH-1:0] r_data_out;

    // Registered read: the popped word appears one cycle after r_en.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data_out <= '0;
        end else if (w_rd_acc) begin
            r_data_out <= r_mem[w_rd_ptr];
        end
    end

    assign bus.data_out = r_data_out;
`endif

    assign bus.count        = r_count;
    assign bus.full         = r_full;
    assign bus.empty        = r_empty;
    assign bus.almost_full  = r_almost_full;
    assign bus.almost_empty = r_almost_empty;
    assign bus.overflow     = r_err.overflow;
    assign bus.underflow    = r_err.underflow;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Scoreboard bench for sync_fifo_flex. A DEPTH=8 instance checks reset
// behaviour; a DEPTH=5 instance runs the directed traffic. Stimulus pushes
// expected read words into a queue; a monitor pops them as the DUT delivers.
module tb_sync_fifo_flex;

    logic clk;
    logic rst_n;

    sync_fifo_flex_if #(.DATA_WIDTH(8), .DEPTH(8)) bus8 ();
    sync_fifo_flex_if #(.DATA_WIDTH(8), .DEPTH(5)) bus5 ();

    sync_fifo_flex #(.DEPTH(8), .DATA_WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    sync_fifo_flex #(.DEPTH(5), .DATA_WIDTH(8)) u_dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    int exp_q[$];   // words the DUT must deliver, oldest first
    int m_q[$];     // model of FIFO contents
    bit exp_ovf = 0;
    bit exp_unf = 0;
    bit mon_pend = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sb_pop(input int act);
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL rd_data: got 0x%0h, expected no read", act);
        end else begin
            chk("rd_data", act, exp_q.pop_front());
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT delivers a read word.
`ifdef SYNC_FIFO_FWFT_EN
    always @(posedge clk) begin
        if (rst_n && bus5.r_en && !bus5.empty) sb_pop(int'(bus5.data_out));
    end
`else
    always @(posedge clk) begin
        mon_pend <= rst_n && bus5.r_en && !bus5.empty;
    end
    always @(negedge clk) begin
        if (mon_pend) sb_pop(int'(bus5.data_out));
    end
`endif

    task automatic chk_flags(input string tag);
        int n;
        n = m_q.size();
        chk({tag, ".count"}, int'(bus5.count), n);
        chk({tag, ".full"}, int'(bus5.full), int'(n == 5));
        chk({tag, ".empty"}, int'(bus5.empty), int'(n == 0));
        chk({tag, ".afull"}, int'(bus5.almost_full), int'(n >= 4));
        chk({tag, ".aempty"}, int'(bus5.almost_empty), int'(n <= 1));
        chk({tag, ".ovf"}, int'(bus5.overflow), int'(exp_ovf));
        chk({tag, ".unf"}, int'(bus5.underflow), int'(exp_unf));
    endtask

    // One clock of traffic on the DEPTH=5 instance, with model update.
    task automatic step(input bit w, input logic [7:0] d, input bit r, input string tag);
        bit ra, wa;
        ra = r && (m_q.size() > 0);
        wa = w && (m_q.size() < 5 || ra);
        if (ra) exp_q.push_back(m_q.pop_front());
        if (wa) m_q.push_back(int'(d));
        exp_ovf = w && !wa;
        exp_unf = r && !ra;
        bus5.w_en    = w;
        bus5.data_in = d;
        bus5.r_en    = r;
        @(posedge clk);
        #1;
        bus5.w_en = 1'b0;
        bus5.r_en = 1'b0;
        chk_flags(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [19:0] w_pat;
        logic [19:0] r_pat;

        // 1: reset with both requests held high
        rst_n = 1'b0;
        bus8.w_en = 1'b1; bus8.r_en = 1'b1; bus8.data_in = 8'hFF;
        bus5.w_en = 1'b1; bus5.r_en = 1'b1; bus5.data_in = 8'hEE;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.empty", int'(bus8.empty), 1);
        chk("rst.full", int'(bus8.full), 0);
        chk("rst.count", int'(bus8.count), 0);
        chk("rst.afull", int'(bus8.almost_full), 0);
        chk("rst.aempty", int'(bus8.almost_empty), 1);
        chk("rst.ovf", int'(bus8.overflow), 0);
        chk("rst.unf", int'(bus8.underflow), 0);
`ifndef SYNC_FIFO_FWFT_EN
        chk("rst.dout", int'(bus8.data_out), 0);
`endif
        chk_flags("rst5");
        bus8.w_en = 1'b0; bus8.r_en = 1'b0;
        bus5.w_en = 1'b0; bus5.r_en = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle8.empty", int'(bus8.empty), 1);

        // 2: fill/drain, DEPTH=5
        step(1, 8'h11, 0, "fill1");
        step(1, 8'h22, 0, "fill2");
        step(1, 8'h33, 0, "fill3");
        chk("af_below", int'(bus5.almost_full), 0);
        step(1, 8'h44, 0, "fill4");
        chk("af_at_4", int'(bus5.almost_full), 1);
        step(1, 8'h55, 0, "fill5");
        chk("full_at_5", int'(bus5.full), 1);
        step(1, 8'h99, 0, "ovf");
        chk("ovf_pulse", int'(bus5.overflow), 1);
        chk("ovf_count", int'(bus5.count), 5);
        step(0, 8'h00, 0, "ovf_clr");
        chk("ovf_one_cycle", int'(bus5.overflow), 0);
        for (int i = 0; i < 5; i++) step(0, 8'h00, 1, "drain");
        chk("drained_empty", int'(bus5.empty), 1);
        step(0, 8'h00, 1, "unf");
        chk("unf_pulse", int'(bus5.underflow), 1);

        // 3: simultaneous write+read while full
        for (int i = 1; i <= 5; i++) step(1, 8'(i * 8'h11), 0, "refill");
        step(1, 8'h66, 1, "full_wr_rd");
        chk("full_wr_rd.count", int'(bus5.count), 5);
        chk("full_wr_rd.ovf", int'(bus5.overflow), 0);
        for (int i = 0; i < 5; i++) step(0, 8'h00, 1, "drain3");

        // 4: simultaneous write+read while empty
        step(1, 8'hA5, 1, "empty_wr_rd");
        chk("empty_wr_rd.unf", int'(bus5.underflow), 1);
        chk("empty_wr_rd.count", int'(bus5.count), 1);
        step(0, 8'h00, 1, "read_a5");

        // 5: interleaved traffic with stalls, crossing the wrap point
        w_pat = 20'b0110_1111_1101_1011_1111;
        r_pat = 20'b1111_0110_0010_1100_1000;
        for (int i = 0; i < 20; i++) begin
            step(w_pat[i], 8'(8'h80 + i), r_pat[i], "wrap");
            chk("wrap.range", int'(bus5.count <= 5), 1);
        end
        while (m_q.size() > 0) step(0, 8'h00, 1, "wrap_drain");

        // 6: first word after empty
        step(1, 8'h3C, 0, "fw_write");
        chk("fw.empty", int'(bus5.empty), 0);
`ifdef SYNC_FIFO_FWFT_EN
        chk("fw.head", int'(bus5.data_out), 8'h3C);
`endif
        step(0, 8'h00, 1, "fw_pop");
        chk("fw.popped_empty", int'(bus5.empty), 1);

        // Reset in the middle of traffic discards contents
        step(1, 8'h71, 0, "pre_rst1");
        step(1, 8'h72, 0, "pre_rst2");
        rst_n = 1'b0;
        bus5.w_en = 1'b1; bus5.data_in = 8'h73;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus5.w_en = 1'b0;
        m_q.delete();
        exp_ovf = 0;
        exp_unf = 0;
        chk_flags("mid_rst");
        step(1, 8'h74, 0, "post_rst");
        step(0, 8'h00, 1, "post_rst_rd");

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
